fifo_synch_mwnr: RTL

Parametrised synchronous multi-write, multi-read FIFO; generalises the 1-write/N-read gather FIFO.
- Accepts 0..N_IN elements per cycle and presents N_OUT-element groups to the consumer with valid/yumi handshaking.
- Adds a drain mode that releases a partial final group, so HE operand streams whose length is not a multiple of N_OUT can be flushed.
- Sits between the operand loaders and the lane-parallel HE compute units.

---
 rtl/fifo_synch_mwnr.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fifo_synch_mwnr.sv
// Synchronous FIFO that accepts up to N_IN elements per cycle and presents
// N_OUT-element read groups with a valid/yumi handshake. A level-sensitive
// drain input releases a partial final group so odd-length streams can flush.
// Storage depth need not be a power of two; pointers wrap by compare/subtract.
module fifo_synch_mwnr #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned N_IN  = 2,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned DEPTH = 16
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [N_IN-1:0][WIDTH-1:0]   data_i,
   input  logic [$clog2(N_IN+1)-1:0]    count_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic                         drain_i,
   output logic                         valid_o,
   output logic [$clog2(N_OUT+1)-1:0]   count_o,
   output logic [N_OUT-1:0][WIDTH-1:0]  data_o,
   output logic [N_OUT-1:0][WIDTH-1:0]  next_data_o,
   input  logic                         yumi_i,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

   localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OccW    = $clog2(DEPTH + 1);
   localparam int unsigned CntOutW = $clog2(N_OUT + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OccW-1:0]  occ_q, occ_d;

   int unsigned occ;
   int unsigned push_n;
   int unsigned pop_n;
   int unsigned grp_n;
   logic        ready;
   logic        valid;

   // Callers never pass more than 3*DEPTH-1, so two conditional subtracts suffice.
   function automatic logic [PtrW-1:0] wrap(input int unsigned v);
      int unsigned r;
      r = v;
      if (r >= DEPTH) r = r - DEPTH;
      if (r >= DEPTH) r = r - DEPTH;
      return PtrW'(r);
   endfunction

   // Handshake decode from registered occupancy; reset forces both sides idle.
   always_comb begin
      occ    = 32'(occ_q);
      ready  = ~reset_i && ((DEPTH - occ) >= N_IN);
      valid  = ~reset_i && ((occ >= N_OUT) || (drain_i && (occ != 0)));
      grp_n  = valid ? ((occ < N_OUT) ? occ : N_OUT) : 0;
      pop_n  = (yumi_i && valid) ? grp_n : 0;
      push_n = 0;
      if (valid_i && ready) begin
         push_n = (32'(count_i) > N_IN) ? N_IN : 32'(count_i);
      end
   end

   // Head group and lookahead group; lanes past the stored data read as zero.
   always_comb begin
      ready_o     = ready;
      valid_o     = valid;
      count_o     = CntOutW'(grp_n);
      occupancy_o = occ_q;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         data_o[k]      = '0;
         next_data_o[k] = '0;
         if (k < grp_n) begin
            data_o[k] = mem_q[wrap(32'(rd_ptr_q) + k)];
         end
         if (!reset_i && (occ > N_OUT + k)) begin
            next_data_o[k] = mem_q[wrap(32'(rd_ptr_q) + N_OUT + k)];
         end
      end
   end

   // Pointer and occupancy next state; pop uses the pre-edge group size.
   always_comb begin
      wr_ptr_d = wrap(32'(wr_ptr_q) + push_n);
      rd_ptr_d = wrap(32'(rd_ptr_q) + pop_n);
      occ_d    = OccW'(occ + push_n - pop_n);
   end

   // Storage next state: write the first push_n lanes starting at wr_ptr.
   always_comb begin
      mem_d = mem_q;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (i < push_n) begin
            mem_d[wrap(32'(wr_ptr_q) + i)] = data_i[i];
         end
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Element storage, cleared on reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule
